// File: rtl/chunked_serial_adder_if.sv
// Operand/result handshake bundle for chunked_serial_adder.
//   master: producer/consumer side (drives operands and out_ready)
//   slave : adder side (drives in_ready and the result)
// Signals: in_valid/in_ready, a, b, sub, cin   -- operand handshake
//          out_valid/out_ready, sum, cout, ovf -- result handshake
interface chunked_serial_adder_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder/subtractor that processes CHUNK bits per clock.
// An operand set is accepted in IDLE, added over N = WIDTH/CHUNK cycles in
// RUN, and the result is held in DONE until the consumer takes it.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - slave side of chunked_serial_adder_if (operands in, result out)
module chunked_serial_adder #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  chunked_serial_adder_if.slave bus
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  int unsigned      base;
  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK-1:0] chunk_s;
  logic             chunk_c;
  logic             carry_into_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    k_d     = k_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    base    = 32'(k_q) * 32'(CHUNK);
    chunk_a = a_q[base +: CHUNK];
    chunk_b = b_q[base +: CHUNK];
    {chunk_c, chunk_s} = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry_q};
    // Carry into the chunk's top bit recovered from that bit's sum equation.
    carry_into_msb = chunk_a[CHUNK-1] ^ chunk_b[CHUNK-1] ^ chunk_s[CHUNK-1];

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[base +: CHUNK] = chunk_s;
        carry_d              = chunk_c;
        if (k_q == KW'(N - 1)) begin
          cout_d  = chunk_c;
          ovf_d   = carry_into_msb ^ chunk_c;
          // Counter parked at 0 rather than N so the chunk select never
          // points past the operand while waiting in DONE.
          k_d     = '0;
          state_d = DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_chunked_serial_adder.sv
module tb_chunked_serial_adder;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  chunked_serial_adder_if #(.WIDTH(64)) bus0 ();
  chunked_serial_adder_if #(.WIDTH(8))  bus1 ();

  chunked_serial_adder #(.WIDTH(64), .CHUNK(16)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  chunked_serial_adder #(.WIDTH(8), .CHUNK(8)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one operand set to dut0, checks acceptance, and waits for DONE.
  task automatic run64(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic sub, input logic cin, input int exp_lat);
    int cyc;
    bus0.a        = a;
    bus0.b        = b;
    bus0.sub      = sub;
    bus0.cin      = cin;
    bus0.in_valid = 1'b1;
    check({tag, "_in_ready"}, 64'(bus0.in_ready), 64'd1);
    tick();
    bus0.in_valid = 1'b0;
    cyc = 0;
    while (!bus0.out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
  endtask

  task automatic release64(input string tag);
    bus0.out_ready = 1'b1;
    tick();
    bus0.out_ready = 1'b0;
    check({tag, "_rel_out_valid"}, 64'(bus0.out_valid), 64'd0);
    check({tag, "_rel_in_ready"}, 64'(bus0.in_ready), 64'd1);
  endtask

  initial begin
    int cyc;
    int seen;
    logic [63:0] held_sum;

    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus0.in_valid  = 1'b0;
    bus0.a         = '0;
    bus0.b         = '0;
    bus0.sub       = 1'b0;
    bus0.cin       = 1'b0;
    bus0.out_ready = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.a         = '0;
    bus1.b         = '0;
    bus1.sub       = 1'b0;
    bus1.cin       = 1'b0;
    bus1.out_ready = 1'b0;

    // Reset state
    #3;
    check("rst_in_ready",  64'(bus0.in_ready),  64'd1);
    check("rst_out_valid", 64'(bus0.out_valid), 64'd0);
    check("rst_sum",       bus0.sum,            64'd0);
    check("rst_cout",      64'(bus0.cout),      64'd0);
    check("rst_ovf",       64'(bus0.ovf),       64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // All-ones + 1 wraps to zero with carry, no signed overflow
    run64("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 4);
    check("wrap_sum",  bus0.sum,        64'd0);
    check("wrap_cout", 64'(bus0.cout),  64'd1);
    check("wrap_ovf",  64'(bus0.ovf),   64'd0);
    release64("wrap");

    // Largest positive + 1 overflows into the sign bit
    run64("pos_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 4);
    check("pos_ovf_sum",  bus0.sum,       64'h8000_0000_0000_0000);
    check("pos_ovf_cout", 64'(bus0.cout), 64'd0);
    check("pos_ovf_ovf",  64'(bus0.ovf),  64'd1);
    release64("pos_ovf");

    // 5 - 7 with cin asserted (must not matter): -2 with borrow
    run64("sub", 64'd5, 64'd7, 1'b1, 1'b1, 4);
    check("sub_sum",  bus0.sum,       64'hFFFF_FFFF_FFFF_FFFE);
    check("sub_cout", 64'(bus0.cout), 64'd0);
    check("sub_ovf",  64'(bus0.ovf),  64'd0);
    release64("sub");

    // Back-pressure in DONE with noisy inputs
    run64("bp", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b1, 4);
    check("bp_sum", bus0.sum, 64'h2222_2222_2222_2212);
    for (int i = 0; i < 10; i++) begin
      bus0.in_valid = ~bus0.in_valid;
      bus0.a        = {$urandom, $urandom};
      bus0.b        = {$urandom, $urandom};
      bus0.sub      = 1'($urandom);
      bus0.cin      = 1'($urandom);
      tick();
      check("bp_hold_sum",       bus0.sum,            64'h2222_2222_2222_2212);
      check("bp_hold_cout",      64'(bus0.cout),      64'd0);
      check("bp_hold_ovf",       64'(bus0.ovf),       64'd0);
      check("bp_hold_out_valid", 64'(bus0.out_valid), 64'd1);
      check("bp_hold_in_ready",  64'(bus0.in_ready),  64'd0);
    end
    // Release with in_valid high: must not be accepted on the same edge
    bus0.a         = 64'd1;
    bus0.b         = 64'd2;
    bus0.sub       = 1'b0;
    bus0.cin       = 1'b0;
    bus0.in_valid  = 1'b1;
    bus0.out_ready = 1'b1;
    tick();
    bus0.out_ready = 1'b0;
    check("bp_rel_in_ready",  64'(bus0.in_ready),  64'd1);
    check("bp_rel_out_valid", 64'(bus0.out_valid), 64'd0);
    check("bp_idle_sum_kept", bus0.sum,            64'h2222_2222_2222_2212);
    run64("bp_next", 64'd1, 64'd2, 1'b0, 1'b0, 4);
    check("bp_next_sum",  bus0.sum,       64'd3);
    check("bp_next_cout", 64'(bus0.cout), 64'd0);
    release64("bp_next");

    // Reset pulse in the middle of RUN (chunk counter at 2)
    bus0.a        = 64'h1111_1111_1111_1111;
    bus0.b        = 64'h2222_2222_2222_2222;
    bus0.sub      = 1'b0;
    bus0.cin      = 1'b0;
    bus0.in_valid = 1'b1;
    tick();
    bus0.in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(bus0.out_valid), 64'd0);
    check("abort_in_ready",  64'(bus0.in_ready),  64'd1);
    check("abort_sum",       bus0.sum,            64'd0);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus0.out_valid) seen++;
    end
    check("abort_no_result", 64'(seen), 64'd0);
    run64("after_abort", 64'd100, 64'd58, 1'b1, 1'b0, 4);
    check("after_abort_sum",  bus0.sum,       64'd42);
    check("after_abort_cout", 64'(bus0.cout), 64'd1);
    check("after_abort_ovf",  64'(bus0.ovf),  64'd0);
    release64("after_abort");

    // Single-chunk instance: WIDTH = CHUNK = 8
    bus1.a        = 8'h80;
    bus1.b        = 8'h80;
    bus1.sub      = 1'b0;
    bus1.cin      = 1'b1;
    bus1.in_valid = 1'b1;
    check("w8_in_ready", 64'(bus1.in_ready), 64'd1);
    tick();
    bus1.in_valid = 1'b0;
    cyc = 0;
    while (!bus1.out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check("w8_latency", 64'(cyc),         64'd1);
    check("w8_sum",     64'(bus1.sum),    64'h01);
    check("w8_cout",    64'(bus1.cout),   64'd1);
    check("w8_ovf",     64'(bus1.ovf),    64'd1);
    bus1.out_ready = 1'b1;
    tick();
    bus1.out_ready = 1'b0;
    check("w8_rel_in_ready", 64'(bus1.in_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
